// File: rtl/uart_pkg.sv
// Shared encodings for the FIFO-fed UART transmitter: FSM state codes and line levels.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_LVL     = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLK_DIV-1 and wraps; tick marks the last cycle of each bit period.
module uart_baud_gen #(
  parameter int CLK_DIV = 868,
  parameter int CWIDTH  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [CWIDTH-1:0] LAST_CNT = CWIDTH'(CLK_DIV - 1);

  logic [CWIDTH-1:0] cnt;

  assign tick = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a syncFifo read port; parity bit compiled in with FIFO_UART_PARITY_EN.
//  state  | meaning
//  IDLE   | line high, waiting for enable && !fifo_empty
//  FETCH  | one-cycle FIFO pop strobe
//  LOAD   | capture fifo_data (1-cycle read latency), clear baud counter
//  START  | start bit
//  DATA   | DWIDTH data bits, LSB first
//  PARITY | parity bit (FIFO_UART_PARITY_EN only)
//  STOP   | STOP_BITS stop bits; tx_done on the very last cycle
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int CLK_DIV    = 868,
  parameter int CWIDTH     = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_rd_cs,
  output logic              fifo_rd_en,
  output logic              txd,
  output logic              busy,
  output logic              tx_done
);

  localparam int IW = $clog2(DWIDTH + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DWIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  uart_state_t       state;
  logic [DWIDTH-1:0] shift_reg;
  logic [IW-1:0]     bit_idx;
  logic              tick;
  logic              baud_clear;

`ifdef FIFO_UART_PARITY_EN
  localparam logic PAR_INIT = (PARITY_ODD != 0);
  logic parity_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Counter held at zero until the start bit so every bit is exactly CLK_DIV cycles.
  assign baud_clear = (state == S_IDLE) || (state == S_FETCH) || (state == S_LOAD);
  assign fifo_rd_cs = fifo_rd_en;
  assign tx_done    = (state == S_STOP) && tick && (bit_idx == LAST_STOP);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV),
    .CWIDTH  (CWIDTH)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  // txd/busy/rd_en are loaded together with the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      txd        <= UART_IDLE_LVL;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
`ifdef FIFO_UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && !fifo_empty) begin
            state      <= S_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shift_reg <= fifo_data;
`ifdef FIFO_UART_PARITY_EN
          parity_bit <= (^fifo_data) ^ PAR_INIT;
`endif
          bit_idx <= '0;
          txd     <= START_LVL;
          state   <= S_START;
        end
        S_START: begin
          if (tick) begin
            txd   <= shift_reg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef FIFO_UART_PARITY_EN
              txd   <= parity_bit;
              state <= S_PARITY;
`else
              txd   <= UART_IDLE_LVL;
              state <= S_STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              txd       <= shift_reg[1];
            end
          end
        end
`ifdef FIFO_UART_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            txd   <= UART_IDLE_LVL;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              // Back-to-back only when data is already waiting; never pops an empty FIFO.
              if (enable && !fifo_empty) begin
                state      <= S_FETCH;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          bit_idx <= '0;
          txd     <= UART_IDLE_LVL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
